// File: rtl/ram_pkg.sv
// Shared types and constants for the synchronous clearable RAM.
package ram_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/ram_sync_clr_if.sv
// Host-side bus of the clearable RAM: address, data, strobes, clear request and busy.
interface ram_sync_clr_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 4
);
  logic [AW-1:0] a;
  logic [DW-1:0] i;
  logic [DW-1:0] d;
  logic          cs_n;
  logic          we_n;
  logic          oe_n;
  logic          clr;
  logic          busy;

  modport master (output a, i, cs_n, we_n, oe_n, clr, input d, busy);
  modport slave  (input a, i, cs_n, we_n, oe_n, clr, output d, busy);
endinterface

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks every address once per pass, after reset or on request.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int unsigned AW             = 8,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          busy_q, busy_d;
  logic          auto_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clr || auto_q) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_CLEAR: begin
        // Restart wins over the terminal count.
        if (clr) begin
          ptr_d = '0;
        end else if (ptr_q == '1) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
          busy_d  = 1'b0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      auto_q  <= (CLEAR_ON_RESET != 0);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      auto_q  <= 1'b0;
    end
  end

  assign busy     = busy_q;
  assign clr_we   = (state_q == ST_CLEAR);
  assign clr_addr = ptr_q;

endmodule

// File: rtl/ram_sync_clr.sv
// Synchronous RAM with registered read port, selectable read-during-write and built-in clear.
module ram_sync_clr
  import ram_pkg::*;
#(
  parameter int unsigned    AW             = 8,
  parameter int unsigned    DW             = 4,
  parameter int unsigned    RDW_MODE       = RDW_READ_FIRST,
  parameter logic [DW-1:0]  CLEAR_VAL      = '0,
  parameter int unsigned    CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  ram_sync_clr_if.slave       bus
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] dreg_q;

  logic          busy;
  logic          clr_we;
  logic [AW-1:0] clr_addr;

  logic          ext_acc;
  logic          ext_we;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          rd_clear;
  logic          rd_fwd;

  ram_clear_seq #(
    .AW             (AW),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_seq (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (bus.clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  always_comb begin
    ext_acc   = reset_n && !bus.cs_n && !busy && !bus.clr;
    ext_we    = ext_acc && !bus.we_n;
    mem_we    = reset_n && (clr_we || ext_we);
    mem_addr  = clr_we ? clr_addr : bus.a;
    mem_wdata = clr_we ? CLEAR_VAL : bus.i;
    rd_clear  = busy && !bus.cs_n;
    rd_fwd    = ext_we && (RDW_MODE == RDW_WRITE_FIRST);
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Array read kept inside the register process so the read port maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dreg_q <= '0;
    end else if (rd_clear) begin
      dreg_q <= CLEAR_VAL;
    end else if (rd_fwd) begin
      dreg_q <= bus.i;
    end else if (ext_acc) begin
      dreg_q <= mem[bus.a];
    end
  end

  assign bus.d    = bus.oe_n ? '0 : dreg_q;
  assign bus.busy = busy;

endmodule

// File: doc/ram_sync_clr.md
# ram_sync_clr

Parametrised synchronous static RAM: the clocked, generalised successor to the 256×4 bipolar RAM models used for the video and motion-object line buffers. It adds configurable width and depth, a registered read port with selectable read-during-write behaviour, and a built-in clear sequencer that walks every address writing a fill value after reset or on request. One instance replaces each bipolar RAM group in the board-level netlist, so software-visible RAM contents start from a known state without a CPU clear loop.

## Interface
- `AW`, 8, address width; depth = 2^AW words
- `DW`, 4, data width
- `RDW_MODE`, 0, read-during-write result: 0 = read-first (old data), 1 = write-first (new data)
- `CLEAR_VAL`, 0, DW-bit fill value written by the clear sequencer
- `CLEAR_ON_RESET`, 1, 1 = run a clear pass automatically after reset release

Ports:
- `clk` in 1: system clock; all state changes on its rising edge
- `reset_n` in 1: synchronous, active-low reset
- `a` in AW: word address
- `i` in DW: write data
- `d` out DW: read data
- `cs_n` in 1: chip select, active low
- `we_n` in 1: write enable, active low; qualified by `cs_n`
- `oe_n` in 1: output enable, active low; combinational gate on `d`
- `clr` in 1: one-cycle request to start a clear pass
- `busy` out 1: registered; high while the clear sequencer owns the array

## Operation
- Array: 2^AW × DW; contents are not affected by `reset_n`. Only the sequencer clears them.
- Write: on an edge with `cs_n`=0, `we_n`=0 and `busy`=0, `mem[a] <= i`.
- Read: on an edge with `cs_n`=0 and `busy`=0, `dreg <= mem[a]`, or `i` when writing in `RDW_MODE`=1. With `cs_n`=1, `dreg` holds its value.
- Output: `d = oe_n ? 0 : dreg`.
- Sequencer FSM has two states, IDLE and CLEAR, with an AW-bit counter `ptr`.
  - IDLE → CLEAR: when `clr`=1, or on the first edge after reset release if `CLEAR_ON_RESET`=1. `ptr` is set to 0.
  - CLEAR: each edge writes `mem[ptr] <= CLEAR_VAL` and increments `ptr`.
  - CLEAR → IDLE: on the edge that writes address 2^AW−1.
  - `clr`=1 while in CLEAR restarts the pass: `ptr` goes to 0 and the state stays CLEAR.
- During CLEAR, external writes are dropped (not queued). External reads load `dreg <= CLEAR_VAL`.
- Counter wrap: `ptr` is AW bits wide. The terminal count is detected at all-ones, not by overflow.

## Timing
- Reset values (edge with `reset_n`=0): state IDLE, `ptr` 0, `dreg` 0, `busy` 0. Therefore `d` = 0.
- Reset mid-clear: the pass is abandoned. The array is left partially cleared. A new pass starts after release if `CLEAR_ON_RESET`=1.
- Read latency is 1 clock: `a` sampled at edge N, data on `d` after edge N (readable before edge N+1).
- `busy` timing:
  - Rises on the same edge that enters CLEAR.
  - Falls on the edge that writes the last address.
  - A full pass holds `busy` high for exactly 2^AW cycles (256 at defaults).
- Access timing:
  - An access on the edge where `busy` falls is still dropped; `busy` is sampled pre-edge.
  - The first accepted access is on the next edge.
- Simultaneous events:
  - `clr` together with an access in IDLE: the access is dropped and CLEAR starts.
  - Same-address write plus read follows `RDW_MODE`.
- `oe_n` has zero-cycle effect on `d`.

## Structure
- Package `ram_pkg`:
  - state enum `{ST_IDLE, ST_CLEAR}`
  - `RDW_READ_FIRST`=0, `RDW_WRITE_FIRST`=1
- Sub-module `ram_clear_seq` holds the FSM, `ptr` and `busy`.
  - Parameters: AW and CLEAR_ON_RESET.
  - Outputs: `busy`, `clr_we`, `clr_addr`.
- Top level holds the array, the write mux (sequencer has priority), `dreg` and the `oe_n` gate. The array must infer block RAM.

## Test plan
- Reset with defaults, hold `reset_n`=0 for 3 clocks, then release → `d`=0; `busy` high for exactly 256 cycles; afterwards reads of addresses 0x00, 0x7F and 0xFF all return 0.
- After clear, write 0xA to address 0x12 then read 0x12 → `d`=0xA one clock after the read edge; `oe_n`=1 forces `d`=0 in the same cycle.
- Same-edge write of 0x5 over 0x3 at address 0x40: `RDW_MODE`=0 → `d`=0x3; `RDW_MODE`=1 → `d`=0x5; both modes then read 0x5 on the next read.
- Write 0xF everywhere, pulse `clr`, then attempt a write of 0x9 to 0x01 at cycle 10 of the pass → write dropped; reads during the pass return 0; afterwards address 0x01 reads 0.
- Pulse `clr` again at cycle 100 of a pass → `busy` stays high for 256 more cycles (356 total).
- Assert `reset_n`=0 at cycle 50 of a pass with `CLEAR_ON_RESET`=0 → `busy`=0 after reset; address 0x10 reads 0; address 0xC0 retains its pre-clear value 0xF.
